id_imm_sched: RTL and testbench
===============================

Name: id_imm_sched

Overview:
- Decode-stage scheduler for the core's immediate generator.
- Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Per instruction, presents the instruction word plus a registered one-hot immediate-select vector, ready to drive the immediate generator's inst/imm_ctrl inputs.
- Sits between IF and EX; also provides flush and a decode-throughput counter.

Parameters:
- CNT_W, 32, width of decoded-instruction counter cnt_o.
- RESET_INST, 32'h00000013, value of inst_o at reset and after flush (NOP).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_inst_i  in  32 (`InstBus)  fetched instruction.
- in_valid_i  in  1  in_inst_i is valid.
- in_ready_o  out  1  block can accept; registered.
- flush_i  in  1  discard all buffered instructions (branch/jump redirect).
- out_inst_o  out  32 (`InstBus)  instruction to immediate generator/EX.
- out_imm_ctrl_o  out  5 (`sw_imm_bus)  one-hot immediate select; bit positions per `IMMJ/`IMMB/`IMMU/`IMMS/`IMMI.
- out_valid_o  out  1  out_* valid.
- out_ready_i  in  1  downstream accepts.
- cnt_o  out  CNT_W  count of output handshakes.

Behaviour:
- Reset (async, rst=1):
  - out_valid_o=0, skid empty, in_ready_o=1.
  - out_inst_o=RESET_INST, out_imm_ctrl_o=0, cnt_o=0.
- Decode on opcode inst[6:0], at capture time; the result is stored with the instruction:
  - 0110111 LUI, 0010111 AUIPC -> IMMU.
  - 1101111 JAL -> IMMJ.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM -> IMMI.
  - 0100011 STORE -> IMMS.
  - 1100011 BRANCH -> IMMB.
  - Any other opcode (incl. OP 0110011, FENCE 0001111) -> all zero.
  - Never more than one bit set.
- Handshake:
  - Input accepted when in_valid_i & in_ready_o.
  - Output transferred when out_valid_o & out_ready_i.
  - in_ready_o = ~skid_valid, driven from a register; no combinational path from out_ready_i to in_ready_o.
- States:
  - EMPTY: out_valid_o=0, skid empty.
  - ONE: out_valid_o=1, skid empty.
  - FULL: out_valid_o=1, skid holds one entry.
- Transitions (no flush):
  - EMPTY + accept -> ONE. Output register loaded; latency 1 cycle from accept to out_valid_o.
  - ONE + accept + transfer -> ONE. Output reloaded with the new instruction.
  - ONE + accept, no transfer -> FULL. New instruction goes to skid.
  - ONE + transfer, no accept -> EMPTY.
  - FULL + transfer -> ONE. Skid moves to output; no accept possible because in_ready_o=0.
  - FULL, no transfer -> hold.
- Order: strict FIFO; no drop or duplication.
- While out_valid_o=1 and out_ready_i=0, out_inst_o and out_imm_ctrl_o are stable.
- flush_i=1 (highest priority, synchronous):
  - Next state EMPTY; out_inst_o=RESET_INST, out_imm_ctrl_o=0.
  - Any same-cycle input is dropped even if in_ready_o=1.
  - A same-cycle output transfer still counts.
- cnt_o:
  - +1 on each output transfer.
  - Wraps modulo 2^CNT_W.
  - Cleared only by rst.
- Reset mid-operation: immediate return to reset values; buffered instructions lost.

Optional Feature:
- Macro: ID_IMM_ILLEGAL_CHK_EN.
- Enabled:
  - Adds output out_illegal_o (1 bit, reset 0), registered alongside each entry.
  - Set when inst[1:0]!=2'b11, or when the opcode is outside the RV32I set listed above plus OP 0110011 and FENCE 0001111.
  - Illegal instructions still flow with out_imm_ctrl_o=0 (EX raises the exception).
  - Cleared by flush.
- Disabled: port absent; unknown opcodes pass with out_imm_ctrl_o=0 and no flag.

Test Plan:
- Reset, then in_inst_i=32'h00500093 (ADDI), valid=1, out_ready_i=1 -> next cycle out_valid_o=1, out_inst_o=00500093, only IMMI set; cnt_o=1 one cycle later.
- Back-to-back stream with out_ready_i=1: LUI 123450B7, JAL 008000EF, SW 00112223, BEQ 00000463 -> one per cycle in order; selects IMMU, IMMJ, IMMS, IMMB; in_ready_o stays 1.
- out_ready_i=0, push 3 instructions -> first two accepted (state FULL), in_ready_o=0 the cycle after the second; outputs stable. Release out_ready_i -> first, then second, delivered on consecutive cycles; third accepted once in_ready_o=1.
- FULL state, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, out_inst_o=00000013, input dropped; cnt_o unchanged unless out_ready_i=1 that cycle.
- Assert rst asynchronously mid-stream (between clock edges) -> outputs go to reset values immediately, cnt_o=0.
- With ID_IMM_ILLEGAL_CHK_EN, in_inst_i=32'h0000007F -> out_illegal_o=1, out_imm_ctrl_o=0. Without the macro -> passes through with out_imm_ctrl_o=0.

Source files
------------

// File: rtl/id_imm_sched.sv
// -----------------------------------------------------------------------------
// id_imm_sched
//
// Decode-stage scheduler for the immediate generator. Fetched instructions
// arrive over a valid/ready handshake and are held in a 2-entry skid buffer
// (output register + skid register). The immediate-select one-hot vector is
// decoded from the opcode when the instruction is captured and travels with it.
//
// Optional feature macro: ID_IMM_ILLEGAL_CHK_EN
//   When defined, adds out_illegal_o, flagging instructions whose low bits are
//   not 2'b11 or whose opcode is outside RV32I.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst            in   asynchronous active-high reset
//   in_inst_i      in   fetched instruction
//   in_valid_i     in   in_inst_i valid
//   in_ready_o     out  block can accept (registered)
//   flush_i        in   discard all buffered instructions
//   out_inst_o     out  instruction to immediate generator / EX
//   out_imm_ctrl_o out  one-hot immediate select (IMMJ/IMMB/IMMU/IMMS/IMMI)
//   out_valid_o    out  out_* valid
//   out_ready_i    in   downstream accepts
//   cnt_o          out  count of output handshakes (wraps)
//   out_illegal_o  out  illegal-instruction flag (only with the macro)
// -----------------------------------------------------------------------------
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef SW_IMM_BUS
`define SW_IMM_BUS 4:0
`endif
`ifndef IMMJ
`define IMMJ 4
`endif
`ifndef IMMB
`define IMMB 3
`endif
`ifndef IMMU
`define IMMU 2
`endif
`ifndef IMMS
`define IMMS 1
`endif
`ifndef IMMI
`define IMMI 0
`endif

module id_imm_sched #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [`InstBus]     in_inst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [`InstBus]     out_inst_o,
  output logic [`SW_IMM_BUS]  out_imm_ctrl_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
`ifdef ID_IMM_ILLEGAL_CHK_EN
  output logic                out_illegal_o,
`endif
  output logic [CNT_W-1:0]    cnt_o
);

  // State encoding: bit0 = output register valid, bit1 = skid register valid.
  // This lets out_valid_o and in_ready_o come straight off flop outputs.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  function automatic logic [`SW_IMM_BUS] f_imm_sel(input logic [6:0] opcode);
    logic [`SW_IMM_BUS] sel;
    sel = '0;
    case (opcode)
      7'b0110111, 7'b0010111:                         sel[`IMMU] = 1'b1;
      7'b1101111:                                     sel[`IMMJ] = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: sel[`IMMI] = 1'b1;
      7'b0100011:                                     sel[`IMMS] = 1'b1;
      7'b1100011:                                     sel[`IMMB] = 1'b1;
      default:                                        sel = '0;
    endcase
    return sel;
  endfunction

`ifdef ID_IMM_ILLEGAL_CHK_EN
  function automatic logic f_illegal(input logic [6:0] opcode);
    logic ill;
    ill = 1'b1;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
      7'b1110011: ill = 1'b0;
      default:    ill = 1'b1;
    endcase
    // Compressed / non-32-bit encodings are never legal here.
    if (opcode[1:0] != 2'b11) ill = 1'b1;
    return ill;
  endfunction
`endif

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [`InstBus]     r_out_inst;
  logic [`SW_IMM_BUS]  r_out_imm;
  logic [`InstBus]     r_skid_inst;
  logic [`SW_IMM_BUS]  r_skid_imm;
  logic [CNT_W-1:0]    r_cnt;
  logic [`SW_IMM_BUS]  w_in_imm;
  logic                w_accept;
  logic                w_xfer;
  logic                w_load_out_in;
  logic                w_load_out_skid;
  logic                w_load_skid;

  assign w_in_imm = f_imm_sel(in_inst_i[6:0]);
  // Flush drops any same-cycle input even when ready is high.
  assign w_accept = in_valid_i & ~r_state[1] & ~flush_i;
  assign w_xfer   = r_state[0] & out_ready_i;

  assign w_load_out_in   = w_accept & ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_xfer));
  assign w_load_skid     = w_accept & (r_state == S_ONE) & ~w_xfer;
  assign w_load_out_skid = ~flush_i & (r_state == S_FULL) & w_xfer;

  // NOTE: combinational next-state logic assigns a default first so no path
  // leaves w_state_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_xfer)      w_state_nxt = S_FULL;
          else if (!w_accept && w_xfer) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_xfer) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its sources regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A transfer in the flush cycle still counts.
      if (w_xfer) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: the two buffer entries are reset too; they are only a few flops and
  // a defined out_inst_o (NOP) after reset is part of the interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_inst  <= RESET_INST;
      r_out_imm   <= '0;
      r_skid_inst <= RESET_INST;
      r_skid_imm  <= '0;
    end else begin
      if (flush_i) begin
        r_out_inst <= RESET_INST;
        r_out_imm  <= '0;
      end else if (w_load_out_in) begin
        r_out_inst <= in_inst_i;
        r_out_imm  <= w_in_imm;
      end else if (w_load_out_skid) begin
        r_out_inst <= r_skid_inst;
        r_out_imm  <= r_skid_imm;
      end
      if (w_load_skid) begin
        r_skid_inst <= in_inst_i;
        r_skid_imm  <= w_in_imm;
      end
    end
  end

`ifdef ID_IMM_ILLEGAL_CHK_EN
  logic r_out_ill;
  logic r_skid_ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_ill  <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (flush_i)              r_out_ill <= 1'b0;
      else if (w_load_out_in)   r_out_ill <= f_illegal(in_inst_i[6:0]);
      else if (w_load_out_skid) r_out_ill <= r_skid_ill;
      if (w_load_skid)          r_skid_ill <= f_illegal(in_inst_i[6:0]);
    end
  end

  assign out_illegal_o = r_out_ill;
`endif

  assign out_valid_o    = r_state[0];
  assign in_ready_o     = ~r_state[1];
  assign out_inst_o     = r_out_inst;
  assign out_imm_ctrl_o = r_out_imm;
  assign cnt_o          = r_cnt;

endmodule

// File: tb/tb_id_imm_sched.sv
module tb_id_imm_sched;

  localparam logic [4:0] SEL_I = 5'b00001;
  localparam logic [4:0] SEL_S = 5'b00010;
  localparam logic [4:0] SEL_U = 5'b00100;
  localparam logic [4:0] SEL_B = 5'b01000;
  localparam logic [4:0] SEL_J = 5'b10000;
  localparam logic [4:0] SEL_0 = 5'b00000;

  logic        clk;
  logic        rst;
  logic [31:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_inst;
  logic [4:0]  out_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cnt;
`ifdef ID_IMM_ILLEGAL_CHK_EN
  logic        out_ill;
`endif

  int checks;
  int failures;

  id_imm_sched dut (
    .clk            (clk),
    .rst            (rst),
    .in_inst_i      (in_inst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .flush_i        (flush),
    .out_inst_o     (out_inst),
    .out_imm_ctrl_o (out_imm),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
`ifdef ID_IMM_ILLEGAL_CHK_EN
    .out_illegal_o  (out_ill),
`endif
    .cnt_o          (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_inst !== 32'h00000013) begin failures++; $display("FAIL reset_inst got=%h exp=00000013", out_inst); end
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL reset_imm got=%b exp=%b", out_imm, SEL_0); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
`ifdef ID_IMM_ILLEGAL_CHK_EN
    checks++; if (out_ill !== 1'b0) begin failures++; $display("FAIL reset_ill got=%b exp=0", out_ill); end
`endif
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_inst = 32'h00500093; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_inst !== 32'h00500093) begin failures++; $display("FAIL single_inst got=%h exp=00500093", out_inst); end
    checks++; if (out_imm !== SEL_I) begin failures++; $display("FAIL single_imm got=%b exp=%b", out_imm, SEL_I); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL single_cnt0 got=%0d exp=0", cnt); end
    step();
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL single_cnt1 got=%0d exp=1", cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [4];
    logic [4:0]  sels  [4];
    insts[0] = 32'h123450B7; sels[0] = SEL_U;
    insts[1] = 32'h008000EF; sels[1] = SEL_J;
    insts[2] = 32'h00112223; sels[2] = SEL_S;
    insts[3] = 32'h00000463; sels[3] = SEL_B;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_inst = insts[i]; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      checks++; if (out_inst !== insts[i]) begin failures++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", i, out_inst, insts[i]); end
      checks++; if (out_imm !== sels[i]) begin failures++; $display("FAIL b2b_imm[%0d] got=%b exp=%b", i, out_imm, sels[i]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    checks++; if (cnt !== 32'd5) begin failures++; $display("FAIL b2b_cnt got=%0d exp=5", cnt); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_inst = 32'h00000297; in_valid = 1'b1;   // A: AUIPC
    step();
    in_inst = 32'hFE010113;                    // B: ADDI
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full_ready got=%b exp=0", in_ready); end
    checks++; if (out_inst !== 32'h00000297) begin failures++; $display("FAIL stall_hold_inst got=%h exp=00000297", out_inst); end
    in_inst = 32'h00A12023;                    // C: SW, must wait
    step();
    checks++; if (out_inst !== 32'h00000297) begin failures++; $display("FAIL stall_stable_inst got=%h exp=00000297", out_inst); end
    checks++; if (out_imm !== SEL_U) begin failures++; $display("FAIL stall_stable_imm got=%b exp=%b", out_imm, SEL_U); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_still_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_inst !== 32'hFE010113) begin failures++; $display("FAIL stall_second got=%h exp=fe010113", out_inst); end
    checks++; if (out_imm !== SEL_I) begin failures++; $display("FAIL stall_second_imm got=%b exp=%b", out_imm, SEL_I); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_reopen got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_inst !== 32'h00A12023) begin failures++; $display("FAIL stall_third got=%h exp=00a12023", out_inst); end
    checks++; if (out_imm !== SEL_S) begin failures++; $display("FAIL stall_third_imm got=%b exp=%b", out_imm, SEL_S); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    checks++; if (cnt !== 32'd8) begin failures++; $display("FAIL stall_cnt got=%0d exp=8", cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_inst = 32'h00000033; in_valid = 1'b1;   // OP
    step();
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL flush_op_imm got=%b exp=%b", out_imm, SEL_0); end
    in_inst = 32'h00100073;                    // EBREAK
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
    flush = 1'b1; in_inst = 32'h123450B7;      // dropped
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    checks++; if (out_inst !== 32'h00000013) begin failures++; $display("FAIL flush_inst got=%h exp=00000013", out_inst); end
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL flush_imm got=%b exp=%b", out_imm, SEL_0); end
    checks++; if (cnt !== 32'd8) begin failures++; $display("FAIL flush_cnt got=%0d exp=8", cnt); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    in_inst = 32'h00000463; in_valid = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (cnt !== 32'd9) begin failures++; $display("FAIL flush_xfer_cnt got=%0d exp=9", cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_xfer_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_inst = 32'h008000EF; in_valid = 1'b1;
    step();
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    checks++; if (out_inst !== 32'h00000013) begin failures++; $display("FAIL arst_inst got=%h exp=00000013", out_inst); end
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL arst_imm got=%b exp=%b", out_imm, SEL_0); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", cnt); end
    in_valid = 1'b0;
    #2 rst = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_inst = 32'h0000007F; in_valid = 1'b1;
    step();
    checks++; if (out_inst !== 32'h0000007F) begin failures++; $display("FAIL ill_inst got=%h exp=0000007f", out_inst); end
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL ill_imm got=%b exp=%b", out_imm, SEL_0); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%b exp=1", out_valid); end
`ifdef ID_IMM_ILLEGAL_CHK_EN
    checks++; if (out_ill !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", out_ill); end
`endif
    in_inst = 32'h00000011;                    // low bits 01
    step();
    checks++; if (out_imm !== SEL_0) begin failures++; $display("FAIL ill_lowbits_imm got=%b exp=%b", out_imm, SEL_0); end
`ifdef ID_IMM_ILLEGAL_CHK_EN
    checks++; if (out_ill !== 1'b1) begin failures++; $display("FAIL ill_lowbits_flag got=%b exp=1", out_ill); end
`endif
    in_inst = 32'h00500093;
    step();
    in_valid = 1'b0;
    checks++; if (out_imm !== SEL_I) begin failures++; $display("FAIL ill_legal_imm got=%b exp=%b", out_imm, SEL_I); end
`ifdef ID_IMM_ILLEGAL_CHK_EN
    checks++; if (out_ill !== 1'b0) begin failures++; $display("FAIL ill_legal_flag got=%b exp=0", out_ill); end
`endif
    step();
    checks++; if (cnt !== 32'd3) begin failures++; $display("FAIL ill_cnt got=%0d exp=3", cnt); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_inst = 32'h0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    test_reset();
    rst = 1'b0;
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
